// File: rtl/store_merge_unit.sv
// Store path for a word-only data memory: sb/sh via read-modify-write, sw direct.
// Illegal size/alignment combinations complete immediately with a misaligned pulse.
module store_merge_unit #(
  parameter int unsigned ADDR_W = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        size,
  input  logic [31:0]       addr,
  input  logic [31:0]       rt_value,
  output logic              busy,
  output logic              done,
  output logic              misaligned,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WT   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [2:0]        state_q, state_d;
  logic              half_q, half_d;
  logic [1:0]        lane_q, lane_d;
  logic [15:0]       rt_q, rt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mis_q, mis_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              illegal_c;
  logic [31:0]       merged_c;

  assign illegal_c = (size == 2'b11)
                   | ((size == SZ_HALF) & addr[0])
                   | ((size == SZ_WORD) & (addr[1:0] != 2'b00));

  // Little-endian lane merge over the word returned by the read.
  always_comb begin
    merged_c = mem_rdata;
    if (half_q) begin
      if (lane_q[1]) merged_c[31:16] = rt_q;
      else           merged_c[15:0]  = rt_q;
    end else begin
      case (lane_q)
        2'd0:    merged_c[7:0]   = rt_q[7:0];
        2'd1:    merged_c[15:8]  = rt_q[7:0];
        2'd2:    merged_c[23:16] = rt_q[7:0];
        default: merged_c[31:24] = rt_q[7:0];
      endcase
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d    = state_q;
    half_d     = half_q;
    lane_d     = lane_q;
    rt_d       = rt_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    mis_d      = 1'b0;
    rd_en_d    = 1'b0;
    wr_en_d    = 1'b0;
    mem_addr_d = mem_addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          half_d = (size == SZ_HALF);
          lane_d = addr[1:0];
          rt_d   = rt_value[15:0];
          busy_d = 1'b1;
          if (illegal_c) begin
            state_d = S_ERR;
            done_d  = 1'b1;
            mis_d   = 1'b1;
          end else if (size == SZ_WORD) begin
            state_d    = S_WR;
            wr_en_d    = 1'b1;
            done_d     = 1'b1;
            mem_addr_d = addr[ADDR_W+1:2];
            wdata_d    = rt_value;
          end else begin
            state_d    = S_RD;
            rd_en_d    = 1'b1;
            mem_addr_d = addr[ADDR_W+1:2];
          end
        end
      end
      S_RD: begin
        state_d = S_WT;
        busy_d  = 1'b1;
      end
      S_WT: begin
        state_d = S_WR;
        busy_d  = 1'b1;
        wr_en_d = 1'b1;
        done_d  = 1'b1;
        wdata_d = merged_c;
      end
      S_WR, S_ERR: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      half_q     <= 1'b0;
      lane_q     <= 2'b00;
      rt_q       <= 16'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mis_q      <= 1'b0;
      mem_addr_q <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wdata_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      lane_q     <= lane_d;
      rt_q       <= rt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mis_q      <= mis_d;
      mem_addr_q <= mem_addr_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      wdata_q    <= wdata_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign misaligned = mis_q;
  assign mem_addr   = mem_addr_q;
  assign mem_rd_en  = rd_en_q;
  assign mem_wr_en  = wr_en_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit with a one-cycle-latency word memory model.
module tb_store_merge_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] rt_value;
  logic        busy;
  logic        done;
  logic        misaligned;
  logic [29:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;

  logic [31:0] mem [0:255];
  logic        ld_en;
  logic [7:0]  ld_a;
  logic [31:0] ld_d;
  int          wr_cnt;
  int          rd_cnt;
  logic        overlap;

  int errors;
  int checks;

  store_merge_unit #(.ADDR_W(30)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .size(size), .addr(addr),
    .rt_value(rt_value), .busy(busy), .done(done), .misaligned(misaligned),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: rdata registered on the read strobe, writes committed on the write strobe.
  always @(posedge clk) begin
    if (ld_en) mem[ld_a] <= ld_d;
    else if (mem_wr_en) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_addr[7:0]];
    if (mem_wr_en) wr_cnt <= wr_cnt + 1;
    if (mem_rd_en) rd_cnt <= rd_cnt + 1;
    if (mem_rd_en && mem_wr_en) overlap <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_a = a; ld_d = d;
    step();
    ld_en = 1'b0;
  endtask

  // Presents one request; returns in the first cycle after the accepting edge.
  task automatic issue(input logic [1:0] s, input logic [31:0] a, input logic [31:0] v);
    size = s; addr = a; rt_value = v; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic chk_err_resp(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_mis"}, 32'(misaligned), 32'd1);
    chk({tag, "_strobes"}, {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
    step();
    chk({tag, "_after"}, {29'd0, done, misaligned, busy}, 32'd0);
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_ctl"}, {26'd0, busy, done, misaligned, mem_rd_en, mem_wr_en, 1'b0}, 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
  endtask

  int wr0;
  int rd0;
  logic [31:0] exp_word;

  initial begin
    errors = 0; checks = 0;
    wr_cnt = 0; rd_cnt = 0; overlap = 1'b0;
    ld_en = 1'b0; ld_a = '0; ld_d = '0;
    rst_n = 1'b0; start = 1'b0; size = 2'b00; addr = '0; rt_value = '0;
    step(); step();
    chk_idle_outs("reset");
    rst_n = 1'b1;
    step();

    // Byte store, lane 2
    load(8'h40, 32'h11223344);
    wr0 = wr_cnt;
    issue(2'b00, 32'h102, 32'hFFFFFFAB);
    chk("byte_c1_rd", {31'd0, mem_rd_en}, 32'd1);
    chk("byte_c1_addr", 32'(mem_addr), 32'h40);
    chk("byte_c1_busy_done", {30'd0, busy, done}, 32'h2);
    step();
    chk("byte_c2_strobes", {29'd0, mem_rd_en, mem_wr_en, done}, 32'd0);
    step();
    chk("byte_c3_done_wr", {29'd0, done, mem_wr_en, misaligned}, 32'h6);
    chk("byte_c3_wdata", mem_wdata, 32'h11AB3344);
    chk("byte_c3_addr", 32'(mem_addr), 32'h40);
    step();
    chk("byte_c4_idle", {30'd0, busy, done}, 32'd0);
    chk("byte_wr_count", 32'(wr_cnt - wr0), 32'd1);

    // Half stores, upper then lower halfword
    load(8'h81, 32'hCAFED00D);
    issue(2'b01, 32'h206, 32'h0000BEEF);
    step(); step();
    chk("half_hi_done_wr", {30'd0, done, mem_wr_en}, 32'h3);
    chk("half_hi_wdata", mem_wdata, 32'hBEEFD00D);
    chk("half_hi_addr", 32'(mem_addr), 32'h81);
    step();
    load(8'h81, 32'hCAFED00D);
    issue(2'b01, 32'h204, 32'h0000BEEF);
    step(); step();
    chk("half_lo_done_wr", {30'd0, done, mem_wr_en}, 32'h3);
    chk("half_lo_wdata", mem_wdata, 32'hCAFEBEEF);
    step();

    // Word store: write one cycle after start, no read
    rd0 = rd_cnt;
    issue(2'b10, 32'h08, 32'hDEADBEEF);
    chk("word_c1_ctl", {28'd0, done, mem_wr_en, mem_rd_en, misaligned}, 32'hC);
    chk("word_c1_wdata", mem_wdata, 32'hDEADBEEF);
    chk("word_c1_addr", 32'(mem_addr), 32'h2);
    step();
    chk("word_no_read", 32'(rd_cnt - rd0), 32'd0);
    chk("word_c2_idle", {30'd0, busy, mem_wr_en}, 32'd0);

    // Illegal requests
    wr0 = wr_cnt; rd0 = rd_cnt;
    issue(2'b01, 32'h03, 32'h1234);
    chk_err_resp("err_half_odd");
    issue(2'b11, 32'h00, 32'h1234);
    chk_err_resp("err_size11");
    issue(2'b10, 32'h02, 32'h1234);
    chk_err_resp("err_word_unal");
    chk("err_no_mem_traffic", 32'((wr_cnt - wr0) + (rd_cnt - rd0)), 32'd0);

    // Back-to-back byte stores with start held high
    load(8'h00, 32'h00000000);
    wr0 = wr_cnt;
    exp_word = 32'h0;
    size = 2'b00; rt_value = 32'h55; addr = 32'h0; start = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b_rd_%0d", i), {31'd0, mem_rd_en}, 32'd1);
      addr = 32'(i + 1);
      step(); step();
      exp_word = exp_word | (32'h55 << (8 * i));
      chk($sformatf("b2b_done_%0d", i), {30'd0, done, mem_wr_en}, 32'h3);
      chk($sformatf("b2b_wdata_%0d", i), mem_wdata, exp_word);
      if (i == 3) start = 1'b0;
      step();
      chk($sformatf("b2b_gap_%0d", i), {29'd0, busy, mem_rd_en, done}, 32'd0);
      step();
    end
    chk("b2b_final_word", exp_word, 32'h55555555);
    chk("b2b_wr_count", 32'(wr_cnt - wr0), 32'd4);
    chk("b2b_after_idle", {30'd0, busy, mem_rd_en}, 32'd0);

    // Reset landing in WT aborts the write
    load(8'h40, 32'h11223344);
    wr0 = wr_cnt;
    issue(2'b00, 32'h101, 32'h77);
    step();
    rst_n = 1'b0;
    #1;
    chk_idle_outs("rst_wt");
    step(); step();
    chk("rst_no_write", 32'(wr_cnt - wr0), 32'd0);
    rst_n = 1'b1;
    step();
    issue(2'b10, 32'h08, 32'h12345678);
    chk("post_rst_ctl", {30'd0, done, mem_wr_en}, 32'h3);
    chk("post_rst_wdata", mem_wdata, 32'h12345678);
    step();
    chk("post_rst_wr_count", 32'(wr_cnt - wr0), 32'd1);
    chk("strobe_exclusive", 32'(overlap), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
